noc_input_port_requester: RTL

- Input-port side of the mesh switch route-reservation protocol.
- Buffers incoming flits and decodes the head flit's destination with XY routing.
- Requests and holds an output path from the switch matrix controller, streams the packet through the mux switch, then relieves the path after the tail flit.
- One instance per switch input port; packets addressed to this node are ejected locally.

---
 rtl/noc_input_port_requester.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/noc_input_port_requester.sv
// rtl/noc_input_port_requester.sv - Mesh switch input port: flit buffer, XY route decode, path reservation and forwarding
//
// Purpose:
//   Buffers upstream flits, decodes the destination of the head flit with
//   XY routing, reserves an output path from the switch matrix controller,
//   streams the packet to the mux switch and releases the path after the tail.
//   Packets addressed to this node are ejected on the local port instead.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_data/in_valid/in_ready upstream flit stream into the input buffer
//   routeReserveRequestValid  reservation request toward the matrix controller
//   routeReserveRequest       requested direction (0 N, 1 S, 2 W, 3 E)
//   routeReserveStatus        grant pulse, honoured only while requesting
//   routeRelieve              one-cycle path release after the tail flit
//   sw_data/sw_valid/sw_ready flit stream toward the mux switch
//   local_*                   ejection stream for packets addressed here
//   timeout_flag              sticky grant-timeout indicator (ROUTE_TIMEOUT_EN only)
//
// Build option:
//   ROUTE_TIMEOUT_EN - re-issue the reservation request after TIMEOUT_CYCLES
//                      without a grant and expose timeout_flag.

module noc_input_port_requester #(
    parameter int N              = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int REQUEST_WIDTH  = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int NODE_X         = 0,
    parameter int NODE_Y         = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic                     routeReserveStatus,
    output logic                     routeRelieve,
    output logic [DATA_WIDTH-1:0]    sw_data,
    output logic                     sw_valid,
    input  logic                     sw_ready,
    output logic [DATA_WIDTH-1:0]    local_data,
    output logic                     local_valid,
    input  logic                     local_ready
`ifdef ROUTE_TIMEOUT_EN
    ,
    output logic                     timeout_flag
`endif
);

    localparam int C  = $clog2(N);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [C-1:0] NODE_X_C = C'(NODE_X);
    localparam logic [C-1:0] NODE_Y_C = C'(NODE_Y);

    localparam logic [REQUEST_WIDTH-1:0] DIR_NORTH = REQUEST_WIDTH'(0);
    localparam logic [REQUEST_WIDTH-1:0] DIR_SOUTH = REQUEST_WIDTH'(1);
    localparam logic [REQUEST_WIDTH-1:0] DIR_WEST  = REQUEST_WIDTH'(2);
    localparam logic [REQUEST_WIDTH-1:0] DIR_EAST  = REQUEST_WIDTH'(3);

    // Elaboration-time guard against unusable parameter combinations.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
        DATA_WIDTH < 2 + 2 * C) begin : g_param_check
        $error("noc_input_port_requester: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_FORWARD,
        S_EJECT,
        S_RELIEVE
    } state_t;

    // ------------------------------------------------------------------
    // Input buffer. Pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  empty, full, wr_en, rd_en;
    logic [DATA_WIDTH-1:0] head_flit;
    logic                  head_is_head, head_is_tail;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_flit = mem_q[rd_ptr_q[AW-1:0]];

    // Type field: bit DW-2 marks a head (01/11), bit DW-1 marks a tail (10/11).
    assign head_is_head = head_flit[DATA_WIDTH-2];
    assign head_is_tail = head_flit[DATA_WIDTH-1];

    // Held low while reset is asserted so every output reads 0 in reset.
    assign in_ready = rst && !full;
    assign wr_en    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // XY route decode of the flit currently at the buffer head.
    // ------------------------------------------------------------------
    logic [C-1:0]             dest_x, dest_y;
    logic [REQUEST_WIDTH-1:0] route_dir;
    logic                     route_local;

    assign dest_x = head_flit[DATA_WIDTH-3 -: C];
    assign dest_y = head_flit[DATA_WIDTH-3-C -: C];

    always_comb begin
        route_dir   = DIR_NORTH;
        route_local = 1'b0;
        if (dest_x > NODE_X_C) begin
            route_dir = DIR_EAST;
        end else if (dest_x < NODE_X_C) begin
            route_dir = DIR_WEST;
        end else if (dest_y > NODE_Y_C) begin
            route_dir = DIR_SOUTH;
        end else if (dest_y < NODE_Y_C) begin
            route_dir = DIR_NORTH;
        end else begin
            route_local = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered request/relieve outputs.
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic                     req_valid_q, req_valid_d;
    logic [REQUEST_WIDTH-1:0] req_dir_q, req_dir_d;
    logic                     relieve_q, relieve_d;
    logic                     grant, sw_xfer, local_xfer, discard;

`ifdef ROUTE_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       timeout_flag_q, timeout_flag_d;
`endif

    assign sw_valid    = (state_q == S_FORWARD) && !empty;
    assign sw_data     = (state_q == S_FORWARD) ? head_flit : '0;
    assign local_valid = (state_q == S_EJECT) && !empty;
    assign local_data  = (state_q == S_EJECT) ? head_flit : '0;

    assign sw_xfer    = sw_valid && sw_ready;
    assign local_xfer = local_valid && local_ready;
    // A stray body/tail flit with no preceding head can never be routed.
    assign discard    = (state_q == S_IDLE) && !empty && !head_is_head;
    assign rd_en      = sw_xfer || local_xfer || discard;

    // Grants are only meaningful while the request is actually on the wire.
    assign grant = (state_q == S_REQUEST) && req_valid_q && routeReserveStatus;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
        end
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty && head_is_head) begin
                    state_d = route_local ? S_EJECT : S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (grant) begin
                    state_d = S_FORWARD;
                end
            end
            S_FORWARD: begin
                if (sw_xfer && head_is_tail) begin
                    state_d = S_RELIEVE;
                end
            end
            S_EJECT: begin
                if (local_xfer && head_is_tail) begin
                    state_d = S_IDLE;
                end
            end
            S_RELIEVE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_valid_d = (state_d == S_REQUEST);
        if (state_d == S_REQUEST) begin
            // Direction is captured on entry and held for the whole request.
            req_dir_d = (state_q == S_IDLE) ? route_dir : req_dir_q;
        end else begin
            req_dir_d = '0;
        end
        relieve_d = (state_d == S_RELIEVE);

`ifdef ROUTE_TIMEOUT_EN
        to_cnt_d       = '0;
        timeout_flag_d = timeout_flag_q;
        if (state_q == S_REQUEST && state_d == S_REQUEST && req_valid_q) begin
            if (to_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                // Drop the request for one cycle, then re-issue it.
                req_valid_d    = 1'b0;
                timeout_flag_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            req_dir_q   <= '0;
            relieve_q   <= 1'b0;
`ifdef ROUTE_TIMEOUT_EN
            to_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_dir_q   <= req_dir_d;
            relieve_q   <= relieve_d;
`ifdef ROUTE_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
            timeout_flag_q <= timeout_flag_d;
`endif
        end
    end

    assign routeReserveRequestValid = req_valid_q;
    assign routeReserveRequest      = req_dir_q;
    assign routeRelieve             = relieve_q;
`ifdef ROUTE_TIMEOUT_EN
    assign timeout_flag = timeout_flag_q;
`endif

endmodule
